data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Responder end of the core's data-memory valid/yumi handshake. Accepts one LD/ST
//  request at a time from the core's to_mem_o/data_mem_addr, performs it on a
//  word-organised SRAM array, and returns a response on from_mem_i after a fixed
//  programmable latency. One outstanding request maximum; sits beside each core.
// PARAMETERS
//  ADDR_WIDTH_P   10  log2 of array depth in 32-bit words
//  LATENCY_P      2   cycles from accept edge to first response-valid cycle (>=1)
// PORTS
//  clk             in   1   single clock, all state on posedge
//  reset           in   1   synchronous, active-high
//  to_mem_i        in   mem_in_s  {write_data[31:0], valid, wen, byte_not_word, yumi}
//  addr_i          in   32  byte address of request, qualified by to_mem_i.valid
//  from_mem_o      out  mem_out_s {read_data[31:0], valid, yumi}
//  misaligned_o    out  1   pulse: accepted word op had addr_i[1:0]!=0
//  busy_o          out  1   state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, from_mem_o.valid=0, from_mem_o.yumi=0, read_data=0,
//   misaligned_o=0, latency counter=0. Array contents NOT cleared. Reset in any state
//   aborts the transaction; a pending response is discarded, a committed write stays.
//  FSM IDLE -> WAIT -> RESP -> IDLE.
//   IDLE: from_mem_o.yumi = to_mem_i.valid (combinational, same cycle). On accept edge:
//    latch wen/byte/lane, perform write or sample read, load counter=LATENCY_P-1,
//    go WAIT (or RESP directly if LATENCY_P==1).
//   WAIT: yumi=0; counter decrements each cycle; at 0 -> RESP next edge.
//   RESP: from_mem_o.valid=1, read_data held stable until to_mem_i.yumi=1; on that edge
//    -> IDLE, valid drops next cycle. New request accepted no earlier than cycle after.
//  Request valid in WAIT/RESP is ignored (no yumi); initiator must keep it held.
//  Response valid first cycle = accept cycle + LATENCY_P; held indefinitely without yumi.
//  Addressing: word index = addr_i[ADDR_WIDTH_P+1:2]; higher bits ignored (wrap).
//   lane = addr_i[1:0]; little-endian, lane 0 = bits[7:0].
//  Word store: write_data -> array[index]; lane ignored; misaligned_o pulses 1 cycle
//   at accept if lane!=0 (operation still performed).
//  Byte store: write_data[7:0] -> array[index][8*lane+:8]; other bytes unchanged.
//  Word load: read_data = array[index]. Byte load: {24'b0, array[index][8*lane+:8]}.
//  Store response: read_data = 32'b0 (core waits on valid for stores too).
//  Array read/write both occur at the accept edge, so back-to-back ST then LD to the
//   same address returns the stored value; no bypass paths needed.
//  to_mem_i.yumi outside RESP: ignored. from_mem_o.yumi never high outside IDLE.
// TESTING
//  1 reset; ST word 0xDEADBEEF @0x10 (LATENCY_P=2) -> yumi same cycle, valid at
//    accept+2, read_data=0; yumi_i -> valid low next cycle, busy_o low.
//  2 LD word @0x10 -> read_data=0xDEADBEEF; then ST byte 0x55 @0x12, LD word @0x10
//    -> 0xDE55BEEF; LD byte @0x13 -> 0x000000DE.
//  3 hold to_mem_i.yumi=0 for 10 cycles in RESP -> valid and read_data stable; second
//    request valid throughout -> no yumi until cycle after response consumed.
//  4 word LD @0x11 -> misaligned_o one-cycle pulse, read_data = word @0x10; addr
//    0x1000+0x10 (ADDR_WIDTH_P=10) aliases to word 4.
//  5 assert reset during WAIT after ST 0x12345678 @0x20 -> valid stays 0, state IDLE;
//    later LD @0x20 -> 0x12345678.
//  6 LATENCY_P=1 build: accept at cycle t, valid at t+1; back-to-back LD/ST stream of
//    32 random ops matches reference array model.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one LD/ST at a time over a valid/yumi handshake,
// performs it on a word SRAM at the accept edge, and responds after LATENCY_P cycles.
package data_mem_pkg;
    typedef struct packed {
        logic [31:0] write_data;
        logic        valid;
        logic        wen;
        logic        byte_not_word;
        logic        yumi;
    } mem_in_s;

    typedef struct packed {
        logic [31:0] read_data;
        logic        valid;
        logic        yumi;
    } mem_out_s;
endpackage

module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH_P = 10,
    parameter int unsigned LATENCY_P    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  mem_in_s     to_mem_i,
    input  logic [31:0] addr_i,
    output mem_out_s    from_mem_o,
    output logic        misaligned_o,
    output logic        busy_o
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH_P;
    localparam int unsigned CNT_W = (LATENCY_P < 2) ? 1 : $clog2(LATENCY_P + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    mis_q, mis_d;
    logic [31:0]             mem_q [DEPTH];

    logic [ADDR_WIDTH_P-1:0] idx;
    logic [1:0]              lane;
    logic [31:0]             rd_word;
    logic [7:0]              rd_byte;
    logic                    yumi;
    logic                    accept;
    logic                    unused_addr_hi;

    assign idx            = addr_i[ADDR_WIDTH_P+1:2];
    assign lane           = addr_i[1:0];
    assign unused_addr_hi = ^addr_i[31:ADDR_WIDTH_P+2];
    assign rd_word        = mem_q[idx];
    assign rd_byte        = rd_word[{lane, 3'b000} +: 8];

    assign yumi   = (state_q == S_IDLE) && to_mem_i.valid && !reset;
    assign accept = yumi;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        mis_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (to_mem_i.wen)
                        rdata_d = '0;
                    else if (to_mem_i.byte_not_word)
                        rdata_d = {24'b0, rd_byte};
                    else
                        rdata_d = rd_word;
                    mis_d   = !to_mem_i.byte_not_word && (lane != 2'b00);
                    cnt_d   = CNT_W'(LATENCY_P - 1);
                    state_d = (LATENCY_P == 1) ? S_RESP : S_WAIT;
                end
            end
            // Leave WAIT on the edge where the counter reaches zero so that
            // valid rises exactly LATENCY_P cycles after the accept cycle.
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1))
                    state_d = S_RESP;
            end
            S_RESP: begin
                if (to_mem_i.yumi)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
        end
    end

    // Array is never cleared; writes commit at the accept edge.
    always_ff @(posedge clk) begin
        if (accept && to_mem_i.wen) begin
            if (to_mem_i.byte_not_word)
                mem_q[idx][{lane, 3'b000} +: 8] <= to_mem_i.write_data[7:0];
            else
                mem_q[idx] <= to_mem_i.write_data;
        end
    end

    always_comb begin
        from_mem_o.read_data = rdata_q;
        from_mem_o.valid     = (state_q == S_RESP);
        from_mem_o.yumi      = yumi;
    end

    assign misaligned_o = mis_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: LATENCY_P=2 instance for directed scenarios,
// LATENCY_P=1 instance for a random back-to-back stream against an array model.
module tb_data_mem_responder;
    import data_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    mem_in_s     tin   [2];
    logic [31:0] taddr [2];
    mem_out_s    tout  [2];
    logic        tmis  [2];
    logic        tbusy [2];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] refm [2][1024];

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_WIDTH_P(10), .LATENCY_P(2)) dut (
        .clk(clk), .reset(rst), .to_mem_i(tin[0]), .addr_i(taddr[0]),
        .from_mem_o(tout[0]), .misaligned_o(tmis[0]), .busy_o(tbusy[0]));

    data_mem_responder #(.ADDR_WIDTH_P(10), .LATENCY_P(1)) dut1 (
        .clk(clk), .reset(rst), .to_mem_i(tin[1]), .addr_i(taddr[1]),
        .from_mem_o(tout[1]), .misaligned_o(tmis[1]), .busy_o(tbusy[1]));

    // Reference: word array, index = byte address / 4 modulo depth, little-endian lanes.
    function automatic logic [31:0] ref_op(int d, bit wen, bit bw, logic [31:0] addr,
                                           logic [31:0] wd);
        int unsigned i  = (addr / 4) % 1024;
        int unsigned sh = (addr % 4) * 8;
        if (wen) begin
            if (bw) refm[d][i] = (refm[d][i] & ~(32'hFF << sh)) | ({24'b0, wd[7:0]} << sh);
            else    refm[d][i] = wd;
            return 32'd0;
        end
        if (bw) return (refm[d][i] >> sh) & 32'hFF;
        return refm[d][i];
    endfunction

    // Drives one request from posedge+1 and consumes the response; reports timing.
    task automatic req(input int d, input bit wen, input bit bw, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd, output int lat,
                       output int acc_wait, output int mis_n);
        rd = '0; lat = -1; mis_n = 0;
        tin[d].valid = 1'b1; tin[d].wen = wen; tin[d].byte_not_word = bw;
        tin[d].write_data = wd; taddr[d] = addr;
        for (acc_wait = 0; acc_wait < 50; acc_wait++) begin
            @(negedge clk);
            if (tout[d].yumi) break;
        end
        @(posedge clk); #1;
        tin[d].valid = 1'b0;
        if (acc_wait >= 50) return;
        for (int k = 1; k < 60; k++) begin
            @(negedge clk);
            if (tmis[d]) mis_n++;
            if (tout[d].valid) begin
                lat = k; rd = tout[d].read_data;
                break;
            end
        end
        if (lat < 0) return;
        tin[d].yumi = 1'b1;
        @(posedge clk); #1;
        tin[d].yumi = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            tin[d] = '0; taddr[d] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            total++; if (tout[d].valid !== 1'b0) begin bad++; $display("FAIL reset_valid dut%0d got=%b exp=0", d, tout[d].valid); end
            total++; if (tout[d].read_data !== 32'h0) begin bad++; $display("FAIL reset_rdata dut%0d got=%h exp=0", d, tout[d].read_data); end
            total++; if (tmis[d] !== 1'b0) begin bad++; $display("FAIL reset_mis dut%0d got=%b exp=0", d, tmis[d]); end
            total++; if (tbusy[d] !== 1'b0) begin bad++; $display("FAIL reset_busy dut%0d got=%b exp=0", d, tbusy[d]); end
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_store_word();
        logic [31:0] rd; int lat, aw, mn;
        void'(ref_op(0, 1, 0, 32'h10, 32'hDEADBEEF));
        req(0, 1, 0, 32'h10, 32'hDEADBEEF, rd, lat, aw, mn);
        total++; if (aw !== 0) begin bad++; $display("FAIL st_yumi_wait got=%0d exp=0", aw); end
        total++; if (lat !== 2) begin bad++; $display("FAIL st_latency got=%0d exp=2", lat); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL st_rdata got=%h exp=0", rd); end
        total++; if (mn !== 0) begin bad++; $display("FAIL st_mis got=%0d exp=0", mn); end
        @(negedge clk);
        total++; if (tout[0].valid !== 1'b0) begin bad++; $display("FAIL st_valid_drop got=%b exp=0", tout[0].valid); end
        total++; if (tbusy[0] !== 1'b0) begin bad++; $display("FAIL st_busy_drop got=%b exp=0", tbusy[0]); end
        @(posedge clk); #1;
    endtask

    task automatic test_load_byte();
        bit          wl [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        bit          bl [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] al [4] = '{32'h10, 32'h12, 32'h10, 32'h13};
        logic [31:0] rd, exp; int lat, aw, mn;
        for (int i = 0; i < 4; i++) begin
            exp = ref_op(0, wl[i], bl[i], al[i], 32'h0000_0055);
            req(0, wl[i], bl[i], al[i], 32'h0000_0055, rd, lat, aw, mn);
            total++; if (rd !== exp) begin bad++; $display("FAIL ldst_data op%0d got=%h exp=%h", i, rd, exp); end
            total++; if (lat !== 2) begin bad++; $display("FAIL ldst_latency op%0d got=%0d exp=2", i, lat); end
        end
    endtask

    task automatic test_hold();
        logic [31:0] rd0, exp0, exp1; int n; bit stable, leak;
        exp0 = ref_op(0, 0, 0, 32'h10, '0);
        exp1 = ref_op(0, 0, 1, 32'h13, '0);
        tin[0].valid = 1'b1; tin[0].wen = 1'b0; tin[0].byte_not_word = 1'b0; taddr[0] = 32'h10;
        for (n = 0; n < 50; n++) begin @(negedge clk); if (tout[0].yumi) break; end
        total++; if (n >= 50) begin bad++; $display("FAIL hold_accept got=timeout exp=accept"); end
        @(posedge clk); #1;
        tin[0].byte_not_word = 1'b1; taddr[0] = 32'h13;
        leak = 1'b0;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (tout[0].yumi) leak = 1'b1;
            if (tout[0].valid) break;
        end
        rd0 = tout[0].read_data;
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (tout[0].valid !== 1'b1 || tout[0].read_data !== rd0) stable = 1'b0;
            if (tout[0].yumi) leak = 1'b1;
        end
        total++; if (rd0 !== exp0) begin bad++; $display("FAIL hold_data got=%h exp=%h", rd0, exp0); end
        total++; if (!stable) begin bad++; $display("FAIL hold_stable got=unstable exp=stable"); end
        tin[0].yumi = 1'b1;
        @(posedge clk); #1;
        tin[0].yumi = 1'b0;
        @(negedge clk);
        total++; if (leak) begin bad++; $display("FAIL hold_no_yumi got=1 exp=0"); end
        total++; if (tout[0].yumi !== 1'b1) begin bad++; $display("FAIL hold_next_accept got=%b exp=1", tout[0].yumi); end
        total++; if (tout[0].valid !== 1'b0) begin bad++; $display("FAIL hold_valid_drop got=%b exp=0", tout[0].valid); end
        @(posedge clk); #1;
        tin[0].valid = 1'b0;
        for (n = 0; n < 50; n++) begin @(negedge clk); if (tout[0].valid) break; end
        total++; if (tout[0].read_data !== exp1) begin bad++; $display("FAIL hold_second got=%h exp=%h", tout[0].read_data, exp1); end
        tin[0].yumi = 1'b1;
        @(posedge clk); #1;
        tin[0].yumi = 1'b0;
    endtask

    task automatic test_misaligned();
        logic [31:0] rd, exp, wd; int lat, aw, mn;
        exp = ref_op(0, 0, 0, 32'h11, '0);
        req(0, 0, 0, 32'h11, '0, rd, lat, aw, mn);
        total++; if (mn !== 1) begin bad++; $display("FAIL mis_pulse got=%0d exp=1", mn); end
        total++; if (rd !== exp) begin bad++; $display("FAIL mis_data got=%h exp=%h", rd, exp); end
        exp = ref_op(0, 0, 0, 32'h1010, '0);
        req(0, 0, 0, 32'h1010, '0, rd, lat, aw, mn);
        total++; if (rd !== exp) begin bad++; $display("FAIL alias_ld got=%h exp=%h", rd, exp); end
        total++; if (mn !== 0) begin bad++; $display("FAIL alias_mis got=%0d exp=0", mn); end
        wd = $urandom;
        void'(ref_op(0, 1, 0, 32'h1014, wd));
        req(0, 1, 0, 32'h1014, wd, rd, lat, aw, mn);
        exp = ref_op(0, 0, 0, 32'h14, '0);
        req(0, 0, 0, 32'h14, '0, rd, lat, aw, mn);
        total++; if (rd !== exp) begin bad++; $display("FAIL alias_st got=%h exp=%h", rd, exp); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd, exp; int lat, aw, mn, n; bit quiet;
        tin[0].valid = 1'b1; tin[0].wen = 1'b1; tin[0].byte_not_word = 1'b0;
        tin[0].write_data = 32'h12345678; taddr[0] = 32'h20;
        for (n = 0; n < 50; n++) begin @(negedge clk); if (tout[0].yumi) break; end
        @(posedge clk); #1;
        tin[0].valid = 1'b0; tin[0].wen = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(ref_op(0, 1, 0, 32'h20, 32'h12345678));
        quiet = 1'b1;
        repeat (6) begin @(negedge clk); if (tout[0].valid !== 1'b0) quiet = 1'b0; end
        total++; if (!quiet) begin bad++; $display("FAIL abort_valid got=1 exp=0"); end
        total++; if (tbusy[0] !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", tbusy[0]); end
        @(posedge clk); #1;
        exp = ref_op(0, 0, 0, 32'h20, '0);
        req(0, 0, 0, 32'h20, '0, rd, lat, aw, mn);
        total++; if (rd !== exp) begin bad++; $display("FAIL abort_commit got=%h exp=%h", rd, exp); end
    endtask

    task automatic test_lat1_stream();
        logic [31:0] rd, exp, wd, addr; int lat, aw, mn, exp_mis; bit wen, bw;
        for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            void'(ref_op(1, 1, 0, 32'(i * 4), wd));
            req(1, 1, 0, 32'(i * 4), wd, rd, lat, aw, mn);
            total++; if (lat !== 1) begin bad++; $display("FAIL l1_init_lat word%0d got=%0d exp=1", i, lat); end
        end
        for (int i = 0; i < 32; i++) begin
            wen  = 1'($urandom_range(0, 1));
            bw   = 1'($urandom_range(0, 1));
            addr = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            wd   = $urandom;
            exp_mis = (!bw && (addr % 4) != 0) ? 1 : 0;
            exp  = ref_op(1, wen, bw, addr, wd);
            req(1, wen, bw, addr, wd, rd, lat, aw, mn);
            total++; if (rd !== exp) begin bad++; $display("FAIL l1_data op%0d addr=%h got=%h exp=%h", i, addr, rd, exp); end
            total++; if (lat !== 1) begin bad++; $display("FAIL l1_lat op%0d got=%0d exp=1", i, lat); end
            total++; if (aw !== 0) begin bad++; $display("FAIL l1_b2b op%0d got=%0d exp=0", i, aw); end
            total++; if (mn !== exp_mis) begin bad++; $display("FAIL l1_mis op%0d got=%0d exp=%0d", i, mn, exp_mis); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_word();
        test_load_byte();
        test_hold();
        test_misaligned();
        test_reset_abort();
        test_lat1_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
